adc_scan_sequencer: RTL and testbench
=====================================

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter NUM_CH, default 17: number of ADC channels scanned, indices 0..NUM_CH-1 (max 32).
REQ-002 Parameter TIMEOUT, default 1023: WAIT-state cycles without a response before abort.
REQ-003 clk_clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a scan.
REQ-006 continuous  in  1  restart scan automatically after each DONE while high.
REQ-007 chan_mask  in  NUM_CH  channel enable mask, sampled at scan start.
REQ-008 busy  out  1  high whenever the FSM is not IDLE.
REQ-009 scan_done  out  1  one-cycle pulse at end of each scan.
REQ-010 cmd_valid / cmd_channel[4:0] / cmd_startofpacket / cmd_endofpacket  out  command stream to ADC control core.
REQ-011 cmd_ready  in  1  command accept from ADC control core.
REQ-012 rsp_valid / rsp_channel[4:0] / rsp_data[11:0] / rsp_startofpacket / rsp_endofpacket  in  response stream from ADC control core.
REQ-013 rd_addr  in  5  sample table read address.
REQ-014 rd_data  out  12  registered sample table read data.
REQ-015 rd_fresh  out  1  registered flag: rd_addr channel written since reset.
REQ-016 err_mismatch / err_timeout  out  1 each  sticky error flags.
REQ-017 err_clear  in  1  clears both error flags.

Function
REQ-018 FSM states SHALL be IDLE, SELECT, CMD, WAIT, DONE.
REQ-019 IDLE + start -> latch chan_mask into mask_q, idx=0, go SELECT; start in any other state SHALL be ignored.
REQ-020 SELECT examines one index per cycle: mask_q[idx]=1 -> CMD; else idx==NUM_CH-1 -> DONE; else idx+1, stay.
REQ-021 CMD: cmd_valid=1, cmd_channel=idx, cmd_startofpacket=cmd_endofpacket=1; payload stable until cmd_valid&cmd_ready; on that cycle go WAIT, clear timeout counter.
REQ-022 cmd_valid SHALL be 0 in every state except CMD; no command is ever withdrawn before acceptance.
REQ-023 WAIT + rsp_valid + rsp_channel==idx -> write rsp_data into sample[idx], set fresh[idx], advance.
REQ-024 WAIT + rsp_valid + rsp_channel!=idx -> no table write, set err_mismatch, advance.
REQ-025 WAIT, counter reaching TIMEOUT with no rsp_valid -> set err_timeout, advance; rsp_valid in the expiry cycle SHALL take precedence over timeout.
REQ-026 Advance: idx==NUM_CH-1 -> DONE; else idx+1 -> SELECT.
REQ-027 rsp_valid outside WAIT SHALL be ignored (no write, no error); rsp_startofpacket/endofpacket are not checked.
REQ-028 DONE lasts one cycle with scan_done=1; then continuous=1 -> re-latch chan_mask, idx=0, SELECT; else IDLE.
REQ-029 Zero mask: scan passes through SELECT for NUM_CH cycles, issues no command, pulses scan_done.
REQ-030 continuous deasserted mid-scan: current scan SHALL complete, then IDLE.
REQ-031 rd_data/rd_fresh SHALL update one cycle after rd_addr; rd_addr>=NUM_CH returns 0/0; same-cycle write and read of one address returns the old value.
REQ-032 err_clear SHALL clear flags; simultaneous set and clear -> set wins.

Reset
REQ-033 reset_reset high SHALL immediately force IDLE, idx=0, mask_q=0, busy=0, scan_done=0, cmd_valid=0, cmd_channel=0, cmd_startofpacket=0, cmd_endofpacket=0, errors=0, all fresh=0, samples=0, rd_data=0, rd_fresh=0.
REQ-034 Reset mid-CMD or mid-WAIT SHALL abandon the transaction; a response arriving after release SHALL be ignored.

Verification
REQ-035 mask=0b101, cmd_ready always 1, responder echoes channel with data 0x100+ch after 3 cycles -> commands ch0 then ch2, sample[0]=0x100, sample[2]=0x102, one scan_done, busy low after.
REQ-036 cmd_ready held low 10 cycles in CMD -> cmd_valid/cmd_channel stable all 10 cycles, exactly one command accepted.
REQ-037 Responder returns channel 5 for command on ch3 -> err_mismatch=1, sample[3] and fresh[3] unchanged, scan continues to next channel.
REQ-038 TIMEOUT=8, no response -> err_timeout=1 after 8 WAIT cycles, scan advances; err_clear pulse -> flag 0.
REQ-039 continuous=1, mask=0b1 -> back-to-back scans with scan_done each scan; drop continuous mid-scan -> exactly one further scan_done, then IDLE.
REQ-040 Assert reset_reset during WAIT -> all outputs at reset values same cycle; late response ignored; mask=0 scan -> no commands, scan_done after NUM_CH SELECT cycles.

Source files
------------

// File: rtl/adc_scan_sequencer_if.sv
// adc_scan_sequencer_if: command and response streams between the scan sequencer and the ADC control core
interface adc_scan_sequencer_if;
  logic cmd_valid;
  logic cmd_ready;
  logic [4:0] cmd_channel;
  logic cmd_startofpacket;
  logic cmd_endofpacket;
  logic rsp_valid;
  logic [4:0] rsp_channel;
  logic [11:0] rsp_data;
  logic rsp_startofpacket;
  logic rsp_endofpacket;
  modport master (
    output cmd_valid, cmd_channel, cmd_startofpacket, cmd_endofpacket,
    input cmd_ready, rsp_valid, rsp_channel, rsp_data, rsp_startofpacket, rsp_endofpacket
  );
  modport slave (
    input cmd_valid, cmd_channel, cmd_startofpacket, cmd_endofpacket,
    output cmd_ready, rsp_valid, rsp_channel, rsp_data, rsp_startofpacket, rsp_endofpacket
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans masked ADC channels one command at a time and keeps a readable sample table
module adc_scan_sequencer #(
  parameter int NUM_CH  = 17,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] chan_mask,
  output logic              busy,
  output logic              scan_done,
  adc_scan_sequencer_if.master bus,
  input  logic [4:0]        rd_addr,
  output logic [11:0]       rd_data,
  output logic              rd_fresh,
  output logic              err_mismatch,
  output logic              err_timeout,
  input  logic              err_clear
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SELECT, CMD, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [4:0] idx, idx_n;
  logic [NUM_CH-1:0] mask_q, fresh;
  logic [CW-1:0] cnt;
  logic [11:0] sample [NUM_CH];
  logic latch, wr, set_mis, set_to, last, in_range, unused_ok;
  assign last = idx == 5'(NUM_CH - 1);
  assign in_range = int'(rd_addr) < NUM_CH;
  assign busy = state != IDLE;
  assign scan_done = state == DONE;
  assign bus.cmd_valid = state == CMD;
  assign bus.cmd_channel = bus.cmd_valid ? idx : '0;
  assign bus.cmd_startofpacket = bus.cmd_valid;
  assign bus.cmd_endofpacket = bus.cmd_valid;
  assign unused_ok = &{1'b0, bus.rsp_startofpacket, bus.rsp_endofpacket};
  always_comb begin
    state_n = state;
    idx_n = idx;
    latch = 1'b0;
    wr = 1'b0;
    set_mis = 1'b0;
    set_to = 1'b0;
    case (state)
      IDLE: begin
        latch = start;
        idx_n = '0;
        state_n = start ? SELECT : IDLE;
      end
      SELECT: begin
        state_n = mask_q[idx] ? CMD : last ? DONE : SELECT;
        idx_n = (mask_q[idx] || last) ? idx : idx + 5'd1;
      end
      CMD: state_n = bus.cmd_ready ? WAIT : CMD;
      WAIT: begin
        // a response in the expiry cycle wins over the timeout
        wr = bus.rsp_valid && bus.rsp_channel == idx;
        set_mis = bus.rsp_valid && bus.rsp_channel != idx;
        set_to = !bus.rsp_valid && cnt == CW'(TIMEOUT - 1);
        if (bus.rsp_valid || set_to) begin
          state_n = last ? DONE : SELECT;
          idx_n = last ? idx : idx + 5'd1;
        end
      end
      DONE: begin
        latch = continuous;
        idx_n = '0;
        state_n = continuous ? SELECT : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
      idx <= '0;
      mask_q <= '0;
      cnt <= '0;
      fresh <= '0;
      err_mismatch <= 1'b0;
      err_timeout <= 1'b0;
      rd_data <= '0;
      rd_fresh <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) sample[i] <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (latch) mask_q <= chan_mask;
      cnt <= state == WAIT ? cnt + CW'(1) : '0;
      if (wr) begin
        sample[idx] <= bus.rsp_data;
        fresh[idx] <= 1'b1;
      end
      err_mismatch <= set_mis | (err_mismatch & ~err_clear);
      err_timeout <= set_to | (err_timeout & ~err_clear);
      rd_data <= in_range ? sample[rd_addr] : '0;
      rd_fresh <= in_range && fresh[rd_addr];
    end
  end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed table-driven scans plus hand sequences for stalls, continuous mode and reset
module tb_adc_scan_sequencer;
  localparam int NUM_CH = 17;
  localparam int TIMEOUT = 8;
  logic clk_clk = 1'b0, reset_reset = 1'b1, start = 1'b0, continuous = 1'b0, err_clear = 1'b0;
  logic [NUM_CH-1:0] chan_mask = '0;
  logic busy, scan_done, rd_fresh, err_mismatch, err_timeout;
  logic [4:0] rd_addr = '0;
  logic [11:0] rd_data;
  adc_scan_sequencer_if bus();
  adc_scan_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start), .continuous(continuous),
    .chan_mask(chan_mask), .busy(busy), .scan_done(scan_done), .bus(bus.master),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_fresh(rd_fresh),
    .err_mismatch(err_mismatch), .err_timeout(err_timeout), .err_clear(err_clear)
  );
  always #5 clk_clk = ~clk_clk;

  int n_pass = 0, n_chk = 0;
  int mode = 0, pend = 0, n_acc = 0, last_ch = -1;
  logic [11:0] base = 12'h100;
  logic [4:0] pend_ch = '0;
  logic [NUM_CH-1:0] seen = '0;
  bit order_ok = 1'b1;
  logic [11:0] exp_sample [32];
  logic exp_fresh [32];

  typedef struct {
    logic [NUM_CH-1:0] mask;
    int mode;
    logic exp_mis;
    logic exp_to;
    int exp_cycles;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // responder: logs accepted commands, answers 3 cycles later unless mode 2
  initial begin
    bus.cmd_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_channel = '0;
    bus.rsp_data = '0;
    bus.rsp_startofpacket = 1'b0;
    bus.rsp_endofpacket = 1'b0;
    forever begin
      @(negedge clk_clk);
      #1;
      bus.rsp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_channel = (mode == 1 && pend_ch == 5'd3) ? 5'd5 : pend_ch;
          bus.rsp_data = base + 12'(pend_ch);
          bus.rsp_startofpacket = 1'b1;
          bus.rsp_endofpacket = 1'b1;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        n_acc++;
        seen[bus.cmd_channel] = 1'b1;
        if (int'(bus.cmd_channel) <= last_ch) order_ok = 1'b0;
        last_ch = int'(bus.cmd_channel);
        if (mode != 2) begin
          pend = 3;
          pend_ch = bus.cmd_channel;
        end
      end
    end
  end

  task automatic clear_log();
    n_acc = 0;
    seen = '0;
    order_ok = 1'b1;
    last_ch = -1;
  endtask

  task automatic run_scan(input logic [NUM_CH-1:0] m, output int cycles, output int dones);
    @(negedge clk_clk);
    clear_log();
    chan_mask = m;
    start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    chan_mask = ~m;
    cycles = 1;
    while (scan_done !== 1'b1 && cycles < 1000) begin
      @(negedge clk_clk);
      cycles++;
    end
    dones = (scan_done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_clk);
      if (scan_done === 1'b1) dones++;
    end
  endtask

  task automatic check_table(input string tag);
    for (int a = 0; a < 20; a++) begin
      rd_addr = 5'(a);
      @(negedge clk_clk);
      check($sformatf("%s_rd_data%0d", tag, a), 32'(rd_data), a < NUM_CH ? 32'(exp_sample[a]) : 32'h0);
      check($sformatf("%s_rd_fresh%0d", tag, a), 32'(rd_fresh), a < NUM_CH ? 32'(exp_fresh[a]) : 32'h0);
    end
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (scan_done !== 1'b1 && c < 500) begin
      @(negedge clk_clk);
      c++;
    end
    check({tag, "_done_seen"}, 32'(scan_done), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, dones, c;
    bit stable;
    vecs[0] = '{17'b101, 0, 1'b0, 1'b0, 26};
    vecs[1] = '{17'h10000, 0, 1'b0, 1'b0, 22};
    vecs[2] = '{17'b11010, 1, 1'b1, 1'b0, 0};
    vecs[3] = '{17'b1000000, 2, 1'b0, 1'b1, 27};
    vecs[4] = '{17'b0, 0, 1'b0, 1'b0, 18};
    for (int i = 0; i < 32; i++) begin
      exp_sample[i] = '0;
      exp_fresh[i] = 1'b0;
    end
    @(negedge clk_clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_scan_done", 32'(scan_done), 0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    check("rst_cmd_channel", 32'(bus.cmd_channel), 0);
    check("rst_cmd_sop", 32'(bus.cmd_startofpacket), 0);
    check("rst_cmd_eop", 32'(bus.cmd_endofpacket), 0);
    check("rst_err_mismatch", 32'(err_mismatch), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_fresh", 32'(rd_fresh), 0);
    reset_reset = 1'b0;
    @(negedge clk_clk);

    for (int r = 0; r < 5; r++) begin
      mode = vecs[r].mode;
      run_scan(vecs[r].mask, cycles, dones);
      for (int ch = 0; ch < NUM_CH; ch++)
        if (vecs[r].mask[ch] && (mode == 0 || (mode == 1 && ch != 3))) begin
          exp_sample[ch] = base + 12'(ch);
          exp_fresh[ch] = 1'b1;
        end
      check($sformatf("row%0d_dones", r), 32'(dones), 1);
      check($sformatf("row%0d_cmd_count", r), 32'(n_acc), 32'($countones(vecs[r].mask)));
      check($sformatf("row%0d_cmd_channels", r), 32'(seen), 32'(vecs[r].mask));
      check($sformatf("row%0d_cmd_order", r), 32'(order_ok), 1);
      check($sformatf("row%0d_err_mismatch", r), 32'(err_mismatch), 32'(vecs[r].exp_mis));
      check($sformatf("row%0d_err_timeout", r), 32'(err_timeout), 32'(vecs[r].exp_to));
      check($sformatf("row%0d_busy_after", r), 32'(busy), 0);
      if (vecs[r].exp_cycles != 0)
        check($sformatf("row%0d_cycles", r), 32'(cycles), 32'(vecs[r].exp_cycles));
      check_table($sformatf("row%0d", r));
      err_clear = 1'b1;
      @(negedge clk_clk);
      err_clear = 1'b0;
      check($sformatf("row%0d_cleared_mis", r), 32'(err_mismatch), 0);
      check($sformatf("row%0d_cleared_to", r), 32'(err_timeout), 0);
    end
    mode = 0;

    // command held while cmd_ready is low
    clear_log();
    bus.cmd_ready = 1'b0;
    chan_mask = 17'b100;
    start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    c = 0;
    while (bus.cmd_valid !== 1'b1 && c < 50) begin
      @(negedge clk_clk);
      c++;
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(bus.cmd_valid === 1'b1 && bus.cmd_channel === 5'd2 && bus.cmd_startofpacket === 1'b1 && bus.cmd_endofpacket === 1'b1)) stable = 1'b0;
      @(negedge clk_clk);
    end
    check("stall_cmd_stable", 32'(stable), 1);
    check("stall_no_accept", 32'(n_acc), 0);
    bus.cmd_ready = 1'b1;
    wait_done("stall");
    repeat (3) @(negedge clk_clk);
    check("stall_one_accept", 32'(n_acc), 1);

    // write and read of the same address in one cycle returns the old value
    rd_addr = 5'd0;
    base = 12'h200;
    @(negedge clk_clk);
    chan_mask = 17'b1;
    start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    c = 0;
    do begin
      @(negedge clk_clk);
      #2;
      c++;
    end while (bus.rsp_valid !== 1'b1 && c < 50);
    @(negedge clk_clk);
    check("same_cycle_old", 32'(rd_data), 32'h100);
    @(negedge clk_clk);
    check("same_cycle_new", 32'(rd_data), 32'h200);
    exp_sample[0] = 12'h200;
    base = 12'h100;
    wait_done("samecyc");
    @(negedge clk_clk);

    // continuous mode, then drop it mid-scan
    continuous = 1'b1;
    chan_mask = 17'b1;
    start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_clk);
      if (scan_done === 1'b1) dones++;
    end
    check("cont_back_to_back", 32'(dones >= 3), 1);
    wait_done("cont");
    repeat (5) @(negedge clk_clk);
    continuous = 1'b0;
    check("cont_busy_mid", 32'(busy), 1);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_clk);
      if (scan_done === 1'b1) dones++;
    end
    check("cont_one_more_done", 32'(dones), 1);
    check("cont_idle_after", 32'(busy), 0);

    // reset during WAIT abandons the transaction
    clear_log();
    chan_mask = 17'b1;
    start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    c = 0;
    do begin
      @(negedge clk_clk);
      #2;
      c++;
    end while (n_acc == 0 && c < 50);
    @(posedge clk_clk);
    #1;
    check("wait_busy_before_rst", 32'(busy), 1);
    reset_reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_cmd_valid", 32'(bus.cmd_valid), 0);
    check("arst_cmd_channel", 32'(bus.cmd_channel), 0);
    check("arst_scan_done", 32'(scan_done), 0);
    check("arst_rd_data", 32'(rd_data), 0);
    check("arst_rd_fresh", 32'(rd_fresh), 0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_sample[i] = '0;
      exp_fresh[i] = 1'b0;
    end
    repeat (6) @(negedge clk_clk);
    check("late_rsp_busy", 32'(busy), 0);
    check("late_rsp_no_mis", 32'(err_mismatch), 0);
    check_table("post_rst");
    run_scan('0, cycles, dones);
    check("zero_mask_dones", 32'(dones), 1);
    check("zero_mask_cycles", 32'(cycles), 32'(NUM_CH + 1));
    check("zero_mask_no_cmd", 32'(n_acc), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
